// File: rtl/servo_pkg.sv
// Shared types and constants for the servo PWM driver.
//   angle_t     8-bit angle command in degrees
//   pulse_us_t  11-bit pulse width in microseconds
//   frame_us_t  15-bit position within the PWM frame, in microseconds
//   US_DIV      clock cycles per microsecond at the default 50 MHz clock
//   SCALE       fixed-point degrees->us factor (Q10) for the default pulse range
//   NUM_CH      number of servo channels
package servo_pkg;

  typedef logic [7:0]  angle_t;
  typedef logic [10:0] pulse_us_t;
  typedef logic [14:0] frame_us_t;

  localparam int unsigned NUM_CH = 4;

  function automatic int unsigned calc_us_div(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // Rounded-up Q10 factor, so the top angle lands exactly on max_us after truncation.
  function automatic int unsigned calc_scale(input int unsigned min_us,
                                             input int unsigned max_us,
                                             input int unsigned angle_max);
    return (((max_us - min_us) << 10) + angle_max - 1) / angle_max;
  endfunction

  localparam int unsigned US_DIV = calc_us_div(50_000_000);
  localparam int unsigned SCALE  = calc_scale(1000, 2000, 180);

endpackage

// File: rtl/servo_channel.sv
// One servo channel: samples the angle command at frame start, optionally slews
// the applied angle, converts it to a pulse width and compares it against the
// frame position to produce the registered PWM output.
// Optional feature: define SERVO_SLEW_EN to limit the applied angle to SLEW_STEP
// degrees of movement per frame.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   enable        1 = drive pulses, 0 = hold pwm_out low
//   frame_strobe  1-cycle pulse in the first cycle of a frame
//   frame_us      current position within the frame, us
//   angle         angle command, degrees
//   pwm_out       registered PWM output
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned ANGLE_MAX    = 180,
  parameter int unsigned ANGLE_RESET  = 90,
  parameter int unsigned SLEW_STEP    = 5,
  parameter int unsigned CH_SCALE     = SCALE
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  logic      frame_strobe,
  input  frame_us_t frame_us,
  input  angle_t    angle,
  output logic      pwm_out
);

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  // A step of 255 can never be exceeded, so the slew path collapses to a direct copy.
  localparam angle_t STEP        = SLEW_EN ? angle_t'(SLEW_STEP) : '1;
  localparam angle_t ANGLE_MAX_A = angle_t'(ANGLE_MAX);
  localparam angle_t ANGLE_RST_A = angle_t'(ANGLE_RESET);

  function automatic pulse_us_t angle_to_pulse(input angle_t a);
    logic [20:0] prod;
    prod = 21'(a) * 21'(CH_SCALE);
    return pulse_us_t'(MIN_PULSE_US) + prod[20:10];
  endfunction

  localparam pulse_us_t PULSE_RST = angle_to_pulse(ANGLE_RST_A);

  angle_t    target_q,  target_d;
  angle_t    applied_q, applied_d;
  pulse_us_t pulse_q,   pulse_d;
  logic      upd_q,     upd_d;
  logic      pwm_q,     pwm_d;

  always_comb begin
    target_d  = target_q;
    applied_d = applied_q;
    upd_d     = frame_strobe;

    if (frame_strobe) begin
      target_d = (angle > ANGLE_MAX_A) ? ANGLE_MAX_A : angle;
    end

    // target_q holds the fresh sample in the cycle after the strobe.
    if (upd_q) begin
      if (target_q > applied_q) begin
        applied_d = ((target_q - applied_q) > STEP) ? applied_q + STEP : target_q;
      end else begin
        applied_d = ((applied_q - target_q) > STEP) ? applied_q - STEP : target_q;
      end
    end

    pulse_d = angle_to_pulse(applied_q);
    pwm_d   = enable & (frame_us < frame_us_t'(pulse_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q  <= ANGLE_RST_A;
      applied_q <= ANGLE_RST_A;
      pulse_q   <= PULSE_RST;
      upd_q     <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      target_q  <= target_d;
      applied_q <= applied_d;
      pulse_q   <= pulse_d;
      upd_q     <= upd_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/servo_pwm_driver.sv
// Four-channel hobby-servo PWM driver: converts angle commands (0..180 deg) into
// standard servo pulses (1.0-2.0 ms in a 20 ms frame). Angles are sampled once per
// frame, so a servo never sees a mid-pulse change.
// Optional feature: define SERVO_SLEW_EN to limit movement to SLEW_STEP deg/frame.
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   enable        1 = drive pulses, 0 = hold all pwm_out low
//   angle1..4     angle commands, degrees (values above ANGLE_MAX are clamped)
//   pwm_out[3:0]  registered servo outputs, bit0 = angle1 ... bit3 = angle4
//   frame_strobe  1-cycle pulse in the cycle a new frame starts
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ       = US_DIV * 1_000_000,
  parameter int unsigned PERIOD_US    = 20000,
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned MAX_PULSE_US = 2000,
  parameter int unsigned ANGLE_MAX    = 180,
  parameter int unsigned ANGLE_RESET  = 90,
  parameter int unsigned SLEW_STEP    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] angle1,
  input  logic [7:0] angle2,
  input  logic [7:0] angle3,
  input  logic [7:0] angle4,
  output logic [3:0] pwm_out,
  output logic       frame_strobe
);

  localparam int unsigned DIV     = calc_us_div(CLK_HZ);
  localparam int unsigned PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CH_SCL  = calc_scale(MIN_PULSE_US, MAX_PULSE_US, ANGLE_MAX);
  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(DIV - 1);
  localparam frame_us_t       FRAME_LAST = frame_us_t'(PERIOD_US - 1);

  logic [PS_W-1:0] prescaler_q, prescaler_d;
  frame_us_t       frame_us_q,  frame_us_d;
  logic            strobe_q,    strobe_d;
  logic            tick;
  angle_t          angle_vec [NUM_CH];

  always_comb begin
    tick        = (prescaler_q == PS_LAST);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    frame_us_d  = frame_us_q;
    strobe_d    = 1'b0;
    if (tick) begin
      if (frame_us_q == FRAME_LAST) begin
        frame_us_d = '0;
        strobe_d   = 1'b1;
      end else begin
        frame_us_d = frame_us_q + frame_us_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      frame_us_q  <= FRAME_LAST;
      strobe_q    <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      frame_us_q  <= frame_us_d;
      strobe_q    <= strobe_d;
    end
  end

  always_comb begin
    angle_vec[0] = angle1;
    angle_vec[1] = angle2;
    angle_vec[2] = angle3;
    angle_vec[3] = angle4;
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    servo_channel #(
      .MIN_PULSE_US (MIN_PULSE_US),
      .ANGLE_MAX    (ANGLE_MAX),
      .ANGLE_RESET  (ANGLE_RESET),
      .SLEW_STEP    (SLEW_STEP),
      .CH_SCALE     (CH_SCL)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .frame_strobe (strobe_q),
      .frame_us     (frame_us_q),
      .angle        (angle_vec[i]),
      .pwm_out      (pwm_out[i])
    );
  end

  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver, built with a 4 MHz clock and a 2050 us
// frame so each frame is 8200 cycles; pulse widths keep their full-size values.
module tb_servo_pwm_driver;

  localparam int US_DIV_TB = 4;
  localparam int PERIOD_TB = 2050;
  localparam int FRAME_CYC = US_DIV_TB * PERIOD_TB;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] angle1, angle2, angle3, angle4;
  logic [3:0] pwm_out;
  logic       frame_strobe;

  int n_checks = 0;
  int n_errors = 0;

  servo_pwm_driver #(
    .CLK_HZ    (US_DIV_TB * 1_000_000),
    .PERIOD_US (PERIOD_TB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .angle1       (angle1),
    .angle2       (angle2),
    .angle3       (angle3),
    .angle4       (angle4),
    .pwm_out      (pwm_out),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedges until frame_strobe is seen, giving up after 'bound'.
  task automatic wait_strobe(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_strobe !== 1'b1 && n < bound);
  endtask

  // Starts at the negedge of a strobe cycle and runs to the next strobe,
  // counting high cycles per channel. Optionally changes angle1 at cycle chg_cycle.
  task automatic measure_frame(input string tag,
                               input int e0, input int e1, input int e2, input int e3,
                               input int chg_cycle, input logic [7:0] chg_val);
    int hi   [4];
    int rise [4];
    int expv [4];
    int n;
    expv = '{e0, e1, e2, e3};
    hi   = '{default: 0};
    rise = '{default: -1};
    n    = 0;
    do begin
      @(negedge clk);
      n++;
      for (int c = 0; c < 4; c++) begin
        if (pwm_out[c] === 1'b1) begin
          hi[c]++;
          if (rise[c] < 0) rise[c] = n;
        end
      end
      if (n == chg_cycle) angle1 = chg_val;
    end while (frame_strobe !== 1'b1 && n < FRAME_CYC + 16);
    check($sformatf("%s_period", tag), n, FRAME_CYC);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s_high%0d", tag, c), hi[c], expv[c] * US_DIV_TB);
      if (expv[c] > 0) check($sformatf("%s_rise%0d", tag, c), rise[c], 1);
    end
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    enable = 1'b1;
`ifdef SERVO_SLEW_EN
    angle1 = 8'd180;
    angle2 = 8'd90;
    angle3 = 8'd87;
    angle4 = 8'd0;
`else
    angle1 = 8'd0;
    angle2 = 8'd90;
    angle3 = 8'd180;
    angle4 = 8'd200;
`endif
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_strobe", int'(frame_strobe), 0);

    rst = 1'b0;
    wait_strobe(64, n);
    check("first_strobe", n, US_DIV_TB);

`ifdef SERVO_SLEW_EN
    // 90 -> 180 rises 5 deg/frame; 90 -> 87 settles at once; 90 -> 0 falls 5 deg/frame.
    measure_frame("slew1", 1527, 1500, 1483, 1472, 0, 8'd0);
    measure_frame("slew2", 1555, 1500, 1483, 1444, 0, 8'd0);
    measure_frame("slew3", 1583, 1500, 1483, 1416, 0, 8'd0);
`else
    measure_frame("cmd", 1000, 1500, 2000, 2000, 0, 8'd0);
    // angle1 goes to 180 at frame_us = 500; current frame must keep 1000 us.
    measure_frame("midchg", 1000, 1500, 2000, 2000, 2000, 8'd180);
    measure_frame("next", 2000, 1500, 2000, 2000, 0, 8'd0);

    enable = 1'b0;
    measure_frame("disabled", 0, 0, 0, 0, 0, 8'd0);

    repeat (400) @(negedge clk);
    check("dis_hold", int'(pwm_out), 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_mid", int'(pwm_out), 15);
    repeat (799) @(negedge clk);
    check("pre_rst", int'(pwm_out), 15);
    angle1 = 8'd90;
    rst    = 1'b1;
    @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    @(negedge clk);
    check("rst_strobe", int'(frame_strobe), 0);
    rst = 1'b0;
    wait_strobe(64, n);
    check("rst_first_strobe", n, US_DIV_TB);
    measure_frame("after_rst", 1500, 1500, 2000, 2000, 0, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
